// File: rtl/exe_pkg.sv
// Shared constants and types for the execute stage.
// Holds ALU opcodes, shift types, NZCV bit indices and the FSM state enum.
package exe_pkg;

   localparam logic [3:0] OP_MOV = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_ADC = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_SBC = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_ORR = 4'b0111;
   localparam logic [3:0] OP_EOR = 4'b1000;
   localparam logic [3:0] OP_MVN = 4'b1001;

   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   localparam int F_N = 3;
   localparam int F_Z = 2;
   localparam int F_C = 1;
   localparam int F_V = 0;

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

endpackage

// File: rtl/exe_stage_pipe_if.sv
// Execute-stage bus: upstream handshake, operands, controls and results.
// master = issuing side (drives instruction), slave = the execute stage.
interface exe_stage_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
) ();

   logic              in_valid;
   logic              in_ready;
   logic              freeze;
   logic              flush;
   logic [DATA_W-1:0] pc_in;
   logic [23:0]       imm24;
   logic [3:0]        ex_cmd;
   logic              mul_en;
   logic              s_en;
   logic [3:0]        sr_in;
   logic [11:0]       shifter_operand;
   logic              imm;
   logic              mem_read_in;
   logic              mem_write_in;
   logic              wb_en_in;
   logic              b_in;
   logic [REG_W-1:0]  dst_in;
   logic [DATA_W-1:0] val_rn_in;
   logic [DATA_W-1:0] val_rm_in;
   logic [1:0]        sel_src1;
   logic [1:0]        sel_src2;
   logic [DATA_W-1:0] mem_fwd_val;
   logic [DATA_W-1:0] wb_fwd_val;

   logic              out_valid;
   logic [DATA_W-1:0] alu_res;
   logic [DATA_W-1:0] store_val;
   logic [DATA_W-1:0] branch_addr;
   logic [3:0]        sr_out;
   logic              sr_we;
   logic              mem_read_out;
   logic              mem_write_out;
   logic              wb_en_out;
   logic              b_out;
   logic [REG_W-1:0]  dst_out;
   logic              busy;

   modport master (
      output in_valid, freeze, flush, pc_in, imm24, ex_cmd, mul_en,
      output s_en, sr_in, shifter_operand, imm, mem_read_in,
      output mem_write_in, wb_en_in, b_in, dst_in, val_rn_in,
      output val_rm_in, sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
      input  in_ready, out_valid, alu_res, store_val, branch_addr,
      input  sr_out, sr_we, mem_read_out, mem_write_out, wb_en_out,
      input  b_out, dst_out, busy
   );

   modport slave (
      input  in_valid, freeze, flush, pc_in, imm24, ex_cmd, mul_en,
      input  s_en, sr_in, shifter_operand, imm, mem_read_in,
      input  mem_write_in, wb_en_in, b_in, dst_in, val_rn_in,
      input  val_rm_in, sel_src1, sel_src2, mem_fwd_val, wb_fwd_val,
      output in_ready, out_valid, alu_res, store_val, branch_addr,
      output sr_out, sr_we, mem_read_out, mem_write_out, wb_en_out,
      output b_out, dst_out, busy
   );

endinterface

// File: rtl/val2_gen.sv
// Operand-2 generator: memory offset, rotated immediate or shifted register.
// Ports: opb (register operand), shifter_operand, imm, mem_acc -> val2.
module val2_gen
   import exe_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] opb,
   input  logic [11:0]       shifter_operand,
   input  logic              imm,
   input  logic              mem_acc,
   output logic [DATA_W-1:0] val2
);

   logic [DATA_W-1:0] imm8;
   logic [DATA_W-1:0] rot_val;
   logic [DATA_W-1:0] sh_val;
   logic [5:0]        rot_amt;
   logic [4:0]        sh_amt;

   always_comb begin
      imm8    = DATA_W'(shifter_operand[7:0]);
      rot_amt = {1'b0, shifter_operand[11:8], 1'b0};
      sh_amt  = shifter_operand[11:7];
      // a left shift by DATA_W yields zero, so a zero rotate is safe
      rot_val = (imm8 >> rot_amt)
              | (imm8 << (DATA_W - int'(rot_amt)));
      sh_val  = opb;
      unique case (shifter_operand[6:5])
         SH_LSL: sh_val = opb << sh_amt;
         SH_LSR: sh_val = opb >> sh_amt;
         SH_ASR: sh_val = DATA_W'($signed(opb) >>> sh_amt);
         SH_ROR: sh_val = (opb >> sh_amt)
                        | (opb << (DATA_W - int'(sh_amt)));
         default: sh_val = opb;
      endcase
      if (mem_acc)
         val2 = DATA_W'(shifter_operand);
      else if (imm)
         val2 = rot_val;
      else
         val2 = sh_val;
   end

endmodule

// File: rtl/exe_stage_pipe.sv
// Execute stage: forwarding muxes, ALU with NZCV, branch adder, multicycle MUL.
// Ports: clk, rst (sync active-low), bus (exe_stage_pipe_if.slave).
module exe_stage_pipe
   import exe_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int REG_W    = 4,
   parameter int MUL_LAT  = 4,
   parameter int BR_SHIFT = 0
) (
   input logic            clk,
   input logic            rst,
   exe_stage_pipe_if.slave bus
);

   localparam int CNT_W = $clog2(MUL_LAT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MUL_LAT - 2);
   localparam int MSB = DATA_W - 1;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] op1, opb, val2, addb, res, br, prod;
   logic [DATA_W:0]   sum;
   logic [3:0]        cmd, flags, mflags;
   logic              mem_acc, cin, arith, known, accept;

   logic [DATA_W-1:0] m_op1, m_opb, m_br;
   logic [3:0]        m_sr;
   logic [REG_W-1:0]  m_dst;
   logic              m_s_en, m_wb, m_b;

   assign mem_acc = bus.mem_read_in | bus.mem_write_in;
   assign bus.in_ready = rst & (state == S_IDLE) & ~bus.freeze;
   assign bus.busy = (state == S_MUL);
   assign accept = bus.in_valid & bus.in_ready;

   always_comb begin
      case (bus.sel_src1)
         2'b01:   op1 = bus.mem_fwd_val;
         2'b10:   op1 = bus.wb_fwd_val;
         default: op1 = bus.val_rn_in;
      endcase
      case (bus.sel_src2)
         2'b01:   opb = bus.mem_fwd_val;
         2'b10:   opb = bus.wb_fwd_val;
         default: opb = bus.val_rm_in;
      endcase
   end

   val2_gen #(.DATA_W(DATA_W)) u_val2 (
      .opb             (opb),
      .shifter_operand (bus.shifter_operand),
      .imm             (bus.imm),
      .mem_acc         (mem_acc),
      .val2            (val2)
   );

   // subtraction is op1 + ~val2 + cin, so carry-out means "no borrow"
   always_comb begin
      cmd   = mem_acc ? OP_ADD : bus.ex_cmd;
      addb  = val2;
      cin   = 1'b0;
      arith = 1'b0;
      known = 1'b1;
      res   = '0;
      unique case (cmd)
         OP_ADD: arith = 1'b1;
         OP_ADC: begin arith = 1'b1; cin = bus.sr_in[F_C]; end
         OP_SUB: begin arith = 1'b1; addb = ~val2; cin = 1'b1; end
         OP_SBC: begin
            arith = 1'b1;
            addb  = ~val2;
            cin   = bus.sr_in[F_C];
         end
         OP_MOV: res = val2;
         OP_MVN: res = ~val2;
         OP_AND: res = op1 & val2;
         OP_ORR: res = op1 | val2;
         OP_EOR: res = op1 ^ val2;
         default: known = 1'b0;
      endcase
      sum = {1'b0, op1} + {1'b0, addb} + (DATA_W + 1)'(cin);
      flags = bus.sr_in;
      if (arith) begin
         res = sum[MSB:0];
         flags[F_C] = sum[DATA_W];
         flags[F_V] = (op1[MSB] == addb[MSB]) & (res[MSB] != op1[MSB]);
      end
      if (known) begin
         flags[F_N] = res[MSB];
         flags[F_Z] = (res == '0);
      end
   end

   always_comb begin
      br = bus.pc_in
         + ({{(DATA_W - 24){bus.imm24[23]}}, bus.imm24} << BR_SHIFT);
      prod = m_op1 * m_opb;
      mflags = {prod[MSB], prod == '0, m_sr[F_C], m_sr[F_V]};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= S_IDLE;
         cnt               <= '0;
         m_op1             <= '0;
         m_opb             <= '0;
         m_br              <= '0;
         m_sr              <= '0;
         m_dst             <= '0;
         m_s_en            <= 1'b0;
         m_wb              <= 1'b0;
         m_b               <= 1'b0;
         bus.out_valid     <= 1'b0;
         bus.alu_res       <= '0;
         bus.store_val     <= '0;
         bus.branch_addr   <= '0;
         bus.sr_out        <= '0;
         bus.sr_we         <= 1'b0;
         bus.mem_read_out  <= 1'b0;
         bus.mem_write_out <= 1'b0;
         bus.wb_en_out     <= 1'b0;
         bus.b_out         <= 1'b0;
         bus.dst_out       <= '0;
      end else if (bus.flush) begin
         state             <= S_IDLE;
         cnt               <= '0;
         bus.out_valid     <= 1'b0;
         bus.sr_we         <= 1'b0;
         bus.mem_read_out  <= 1'b0;
         bus.mem_write_out <= 1'b0;
         bus.wb_en_out     <= 1'b0;
         bus.b_out         <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept && bus.mul_en) begin
                  state         <= S_MUL;
                  cnt           <= '0;
                  m_op1         <= op1;
                  m_opb         <= opb;
                  m_br          <= br;
                  m_sr          <= bus.sr_in;
                  m_dst         <= bus.dst_in;
                  m_s_en        <= bus.s_en;
                  m_wb          <= bus.wb_en_in;
                  m_b           <= bus.b_in;
                  bus.out_valid <= 1'b0;
                  bus.sr_we     <= 1'b0;
               end else if (accept) begin
                  bus.out_valid     <= 1'b1;
                  bus.alu_res       <= res;
                  bus.store_val     <= opb;
                  bus.branch_addr   <= br;
                  bus.sr_out        <= flags;
                  bus.sr_we         <= bus.s_en;
                  bus.mem_read_out  <= bus.mem_read_in;
                  bus.mem_write_out <= bus.mem_write_in;
                  bus.wb_en_out     <= bus.wb_en_in;
                  bus.b_out         <= bus.b_in;
                  bus.dst_out       <= bus.dst_in;
               end else if (!bus.freeze) begin
                  bus.out_valid <= 1'b0;
                  bus.sr_we     <= 1'b0;
               end
            end
            S_MUL: begin
               if (cnt != LAST) begin
                  cnt <= cnt + 1'b1;
                  if (!bus.freeze) begin
                     bus.out_valid <= 1'b0;
                     bus.sr_we     <= 1'b0;
                  end
               end else if (!bus.freeze) begin
                  // completion; under freeze the counter stays at LAST
                  state             <= S_IDLE;
                  cnt               <= '0;
                  bus.out_valid     <= 1'b1;
                  bus.alu_res       <= prod;
                  bus.store_val     <= m_opb;
                  bus.branch_addr   <= m_br;
                  bus.sr_out        <= mflags;
                  bus.sr_we         <= m_s_en;
                  bus.mem_read_out  <= 1'b0;
                  bus.mem_write_out <= 1'b0;
                  bus.wb_en_out     <= m_wb;
                  bus.b_out         <= m_b;
                  bus.dst_out       <= m_dst;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Scoreboard bench for exe_stage_pipe: directed ALU, forwarding, MUL, flush, reset.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_exe_stage_pipe;
   import exe_pkg::*;

   localparam int DW = 32;
   localparam int RW = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   exe_stage_pipe_if #(.DATA_W(DW), .REG_W(RW)) bus ();

   exe_stage_pipe #(
      .DATA_W(DW), .REG_W(RW), .MUL_LAT(4), .BR_SHIFT(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      string       nm;
      logic [31:0] alu, st, br;
      logic [3:0]  sr;
      logic        we, mr, mw, wb, b;
      logic [3:0]  dst;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int total = 0;
   int bad = 0;
   logic frz_q = 1'b0;
   logic seen;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic void push(input string nm,
                                input logic [31:0] alu, st, br,
                                input logic [3:0] sr,
                                input logic we, mr, mw, b);
      exp_t e;
      e.nm = nm; e.alu = alu; e.st = st; e.br = br; e.sr = sr;
      e.we = we; e.mr = mr; e.mw = mw; e.wb = 1'b1; e.b = b;
      e.dst = 4'h5;
      q.push_back(e);
   endfunction

   always @(posedge clk) frz_q <= bus.freeze;

   always @(negedge clk) begin
      if (rst && bus.out_valid && !frz_q) begin
         if (q.size() == 0) begin
            chk("unexpected_out", 32'(bus.out_valid), 32'd0);
         end else begin
            m_e = q.pop_front();
            chk({m_e.nm, "_alu"}, bus.alu_res, m_e.alu);
            chk({m_e.nm, "_store"}, bus.store_val, m_e.st);
            chk({m_e.nm, "_br"}, bus.branch_addr, m_e.br);
            chk({m_e.nm, "_sr"}, 32'(bus.sr_out), 32'(m_e.sr));
            chk({m_e.nm, "_ctl"},
                32'({bus.sr_we, bus.mem_read_out, bus.mem_write_out,
                     bus.wb_en_out, bus.b_out, bus.dst_out}),
                32'({m_e.we, m_e.mr, m_e.mw, m_e.wb, m_e.b, m_e.dst}));
         end
      end
   end

   task automatic set_alu(input logic [3:0] cmd, input logic [31:0] rn,
                          input logic [31:0] rm, input logic [11:0] so,
                          input logic im, input logic se,
                          input logic [3:0] sr);
      bus.ex_cmd = cmd; bus.val_rn_in = rn; bus.val_rm_in = rm;
      bus.shifter_operand = so; bus.imm = im; bus.s_en = se;
      bus.sr_in = sr; bus.sel_src1 = 2'b00; bus.sel_src2 = 2'b00;
      bus.mem_fwd_val = '0; bus.wb_fwd_val = '0; bus.mul_en = 1'b0;
      bus.mem_read_in = 1'b0; bus.mem_write_in = 1'b0;
      bus.wb_en_in = 1'b1; bus.b_in = 1'b0; bus.dst_in = 4'h5;
      bus.pc_in = '0; bus.imm24 = '0;
   endtask

   task automatic fire(input string nm);
      bus.in_valid = 1'b1;
      chk({nm, "_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.mul_en = 1'b0;
   endtask

   task automatic no_stale(input string nm);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen = seen | bus.out_valid;
      end
      chk(nm, 32'(seen), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bus.in_valid = 1'b0; bus.freeze = 1'b0; bus.flush = 1'b0;
      set_alu(4'h0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_alu", bus.alu_res, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_sr", 32'(bus.sr_out), 32'd0);
      rst = 1'b1;
      @(negedge clk);

      set_alu(OP_ADD, 5, 0, 12'h003, 1, 0, 0);
      push("add", 8, 0, 0, 4'b0000, 0, 0, 0, 0);
      fire("add");
      chk("add_latency", 32'(bus.out_valid), 32'd1);

      set_alu(OP_SUB, 3, 0, 12'h003, 1, 1, 0);
      push("sub", 0, 0, 0, 4'b0110, 1, 0, 0, 0);
      fire("sub");

      set_alu(OP_ADD, 32'h7FFF_FFFF, 0, 12'h001, 1, 1, 0);
      push("addv", 32'h8000_0000, 0, 0, 4'b1001, 1, 0, 0, 0);
      fire("addv");

      set_alu(OP_MOV, 32'hDEAD, 32'hBEEF, 12'h100, 0, 0, 0);
      bus.sel_src1 = 2'b01; bus.mem_fwd_val = 32'h100;
      bus.sel_src2 = 2'b10; bus.wb_fwd_val = 32'h4;
      push("fwd", 32'h10, 32'h4, 0, 4'b0000, 0, 0, 0, 0);
      fire("fwd");

      set_alu(OP_MOV, 0, 0, 12'h1FF, 1, 1, 4'b0011);
      push("rot", 32'hC000_003F, 0, 0, 4'b1011, 1, 0, 0, 0);
      fire("rot");

      set_alu(OP_MOV, 0, 32'h8000_0000, 12'h240, 0, 0, 0);
      push("asr", 32'hF800_0000, 32'h8000_0000, 0, 4'b1000, 0, 0, 0, 0);
      fire("asr");

      set_alu(OP_EOR, 32'hF0F0_F0F0, 0, 12'h0FF, 1, 0, 0);
      push("eor", 32'hF0F0_F00F, 0, 0, 4'b1000, 0, 0, 0, 0);
      fire("eor");

      set_alu(OP_ADC, 1, 0, 12'h001, 1, 0, 4'b0010);
      push("adc", 3, 0, 0, 4'b0000, 0, 0, 0, 0);
      fire("adc");

      set_alu(4'b0000, 5, 0, 12'h001, 1, 1, 4'b1010);
      push("nop", 0, 0, 0, 4'b1010, 1, 0, 0, 0);
      fire("nop");

      set_alu(OP_MOV, 32'h1000, 32'h77, 12'h804, 1, 0, 0);
      bus.mem_read_in = 1'b1;
      push("mem", 32'h1804, 32'h77, 0, 4'b0000, 0, 1, 0, 0);
      fire("mem");

      set_alu(OP_MOV, 0, 0, 12'h000, 1, 0, 0);
      bus.pc_in = 32'h100; bus.imm24 = 24'hFFFFFC; bus.b_in = 1'b1;
      push("br", 0, 0, 32'hF0, 4'b0100, 0, 0, 0, 1);
      fire("br");

      @(negedge clk);
      chk("idle_drop", 32'(bus.out_valid), 32'd0);

      set_alu(OP_ADD, 7, 6, 12'h000, 0, 1, 4'b0011);
      bus.mul_en = 1'b1; bus.mem_write_in = 1'b1;
      push("mul", 42, 6, 0, 4'b0011, 1, 0, 0, 0);
      fire("mul");
      for (int i = 0; i < 3; i++) begin
         chk("mul_busy", 32'(bus.busy), 32'd1);
         chk("mul_ready", 32'(bus.in_ready), 32'd0);
         chk("mul_valid", 32'(bus.out_valid), 32'd0);
         @(negedge clk);
      end
      chk("mul_done", 32'(bus.out_valid), 32'd1);
      chk("mul_idle", 32'(bus.busy), 32'd0);
      bus.mem_write_in = 1'b0;
      @(negedge clk);

      set_alu(OP_ADD, 3, 5, 12'h000, 0, 0, 4'b0000);
      bus.mul_en = 1'b1;
      push("mulfrz", 15, 5, 0, 4'b0000, 0, 0, 0, 0);
      fire("mulfrz");
      @(negedge clk);
      bus.freeze = 1'b1;
      @(negedge clk);
      chk("frz_busy1", 32'(bus.busy), 32'd1);
      chk("frz_valid1", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      chk("frz_busy2", 32'(bus.busy), 32'd1);
      chk("frz_valid2", 32'(bus.out_valid), 32'd0);
      bus.freeze = 1'b0;
      @(negedge clk);
      chk("frz_done", 32'(bus.out_valid), 32'd1);
      chk("frz_idle", 32'(bus.busy), 32'd0);
      @(negedge clk);

      set_alu(OP_ADD, 9, 9, 12'h000, 0, 1, 4'b0000);
      bus.mul_en = 1'b1;
      fire("flush");
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      chk("flush_valid", 32'(bus.out_valid), 32'd0);
      chk("flush_busy", 32'(bus.busy), 32'd0);
      chk("flush_ready", 32'(bus.in_ready), 32'd1);
      no_stale("flush_stale");

      set_alu(OP_ADD, 9, 9, 12'h000, 0, 1, 4'b0000);
      bus.mul_en = 1'b1;
      fire("rstmul");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("rstmul_valid", 32'(bus.out_valid), 32'd0);
      chk("rstmul_busy", 32'(bus.busy), 32'd0);
      chk("rstmul_alu", bus.alu_res, 32'd0);
      no_stale("rstmul_stale");

      chk("queue_empty", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exe_stage_pipe.md
EXE_STAGE_PIPE -- requirements
Module: exe_stage_pipe

Interface
REQ-001 Parameters SHALL be:
- DATA_W, 32, datapath width; must be >= 32.
- REG_W, 4, register-index width.
- MUL_LAT, 4, multiply latency in cycles; must be >= 2.
- BR_SHIFT, 0, left shift applied to the sign-extended imm24 before the branch add.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage accepts this cycle.
- freeze  in  1  downstream hold.
- flush  in  1  kill in-flight and accepted work.
- pc_in  in  DATA_W  instruction PC.
- imm24  in  24  branch offset.
- ex_cmd  in  4  ALU opcode.
- mul_en  in  1  multiply; overrides ex_cmd.
- s_en  in  1  update flags.
- sr_in  in  4  current NZCV.
- shifter_operand  in  12  operand-2 field.
- imm  in  1  immediate operand-2.
- mem_read_in, mem_write_in, wb_en_in, b_in  in  1 each  control.
- dst_in  in  REG_W  destination register.
- val_rn_in, val_rm_in  in  DATA_W  register-file operands.
- sel_src1, sel_src2  in  2  forward select: 00 reg, 01 mem_fwd_val, 10 wb_fwd_val, 11 reg.
- mem_fwd_val, wb_fwd_val  in  DATA_W  forwarded values.
- out_valid  out  1  output register holds a live instruction.
- alu_res, store_val, branch_addr  out  DATA_W  registered results.
- sr_out  out  4  registered NZCV.
- sr_we  out  1  flag write enable.
- mem_read_out, mem_write_out, wb_en_out, b_out  out  1 each  registered control.
- dst_out  out  REG_W  registered destination.
- busy  out  1  multiply in flight.

Function
REQ-003 op1 SHALL be the sel_src1-selected Rn value; opB SHALL be the sel_src2-selected Rm value; store_val SHALL capture opB.
REQ-004 val2 SHALL be:
- mem_read_in|mem_write_in: zero-extended shifter_operand[11:0].
- else imm: zero-extended [7:0] rotated right by 2*[11:8].
- else: opB shifted by [11:7] per [6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
REQ-005 ALU ops on (op1, val2) SHALL be:
- 0001 MOV=val2; 1001 MVN=~val2.
- 0010 ADD; 0011 ADC (+C).
- 0100 SUB; 0101 SBC (-!C).
- 0110 AND; 0111 ORR; 1000 EOR.
- Memory access forces ADD.
- Other codes: result 0, flags unchanged.
REQ-006 Flags: N=res[DATA_W-1]; Z=(res==0); C,V from arithmetic ops only; logical ops pass C,V from sr_in.
REQ-007 branch_addr SHALL be pc_in + (sign-extended imm24 << BR_SHIFT), modulo 2^DATA_W.
REQ-008 FSM SHALL have states IDLE and MUL; in_ready = (state==IDLE) & !freeze; busy = (state==MUL).
REQ-009 IDLE, accept (in_valid & in_ready), mul_en=0: next edge loads all outputs, out_valid=1, sr_we=s_en (1-cycle latency).
REQ-010 IDLE, accept, mul_en=1: capture op1, opB and control, go to MUL, out_valid=0 next edge.
REQ-011 MUL: counter runs MUL_LAT-1 cycles; last cycle loads alu_res=low DATA_W bits of op1*opB, N/Z updated, C/V kept, returns to IDLE (total latency MUL_LAT).
REQ-012 MUL completion under freeze SHALL stall in MUL, counter saturated, until freeze=0.
REQ-013 No accept and no MUL completion: out_valid=0 next edge, unless freeze=1, which holds every output.
REQ-014 flush SHALL beat freeze and accept: next edge out_valid=0, sr_we=0, control outs 0, state IDLE, counter 0.
REQ-015 Multiply with mem_read_in or mem_write_in set: mem flags ignored, result still MUL.

Reset
REQ-016 With rst=0 at an edge, all outputs SHALL be 0, state IDLE, counter 0; this aborts an in-flight multiply.
REQ-017 in_ready SHALL be 0 while rst=0.

Structure
REQ-018 Shared package exe_pkg SHALL hold the ALU opcode constants, shift-type constants, the NZCV bit indices and the FSM state enum.
REQ-019 val2 generation SHALL be sub-module val2_gen, parameterised by DATA_W; ALU and FSM stay in exe_stage_pipe.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- ADD: Rn=5, imm=1, operand 0x003 -> next cycle alu_res=8, out_valid=1.
- SUB with s_en: 3-3 -> Z=1, C=1, sr_we=1; 0x7FFFFFFF ADD 1 -> N=1, V=1.
- Forwarding: sel_src1=01, mem_fwd_val=0x100; sel_src2=10, wb_fwd_val=0x4, LSL 2 (MOV) -> alu_res=0x10; store_val=4.
- MUL: 7*6, MUL_LAT=4 -> busy for 3 cycles, in_ready=0, alu_res=42 on cycle 4; freeze at completion delays result by the freeze length.
- flush during MUL cycle 2, and rst=0 mid-MUL -> out_valid=0, busy=0 next edge, no stale result later.
- Branch: pc_in=0x100, imm24=0xFFFFFC, BR_SHIFT=2 -> branch_addr=0xF0.
